// File: rtl/traffic_sensor_cond.sv
// Car-presence conditioning: per-street synchroniser, arrival debounce and post-departure hold.
// Optional per-street arrival counters are built when TSC_CAR_COUNT_EN is defined.
module traffic_sensor_cond #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned HOLD_CYCLES = 200_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       sa,
    output logic       sb,
    output logic       arr_a,
`ifdef TSC_CAR_COUNT_EN
    output logic       arr_b,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
`else
    output logic       arr_b
`endif
);

    localparam int unsigned MAX_CYCLES = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StPresent,
        StHold
    } state_e;

    logic [1:0] raw;
    logic [1:0] pres;
    logic [1:0] arr;

    assign raw = {raw_b, raw_a};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;
        state_e                 state_q, state_d;
        logic [CW-1:0]          cnt_q, cnt_d;
        logic                   pres_q;
        logic                   arr_q;

        assign sync = sync_q[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q  <= '0;
                state_q <= StIdle;
                cnt_q   <= '0;
                pres_q  <= 1'b0;
                arr_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pres_q  <= (state_q == StPresent) || (state_q == StHold);
                // PRESENT with pres_q still low can only follow QUAL: a genuinely new arrival.
                arr_q   <= (state_q == StPresent) && !pres_q;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                StIdle: begin
                    if (sync) begin
                        state_d = StQual;
                        cnt_d   = '0;
                    end
                end
                StQual: begin
                    if (!sync) begin
                        state_d = StIdle;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = StPresent;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StPresent: begin
                    if (!sync) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end
                end
                StHold: begin
                    if (sync) begin
                        state_d = StPresent;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        assign pres[ch] = pres_q;
        assign arr[ch]  = arr_q;
    end

    assign sa    = pres[0];
    assign sb    = pres[1];
    assign arr_a = arr[0];
    assign arr_b = arr[1];

`ifdef TSC_CAR_COUNT_EN
    logic [1:0][7:0] car_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            car_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (arr[i] && (car_q[i] != 8'hFF)) begin
                    car_q[i] <= car_q[i] + 8'd1;
                end
            end
        end
    end

    assign cnt_a = car_q[0];
    assign cnt_b = car_q[1];
`endif

endmodule
